sobel_core: RTL and testbench

SOBEL_CORE -- requirements
Module: sobel_core

---
 rtl/sobel_core.sv | 129 ++++++++++++
 tb/tb_sobel_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_core.sv
// Streaming 3x3 Sobel edge detector: column window, gradient stage, then
// saturated |Gx|+|Gy| magnitude with threshold flag.
module sobel_core #(
  parameter int DW     = 10,
  parameter int LINE_W = 480,
  parameter int THRESH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] row0_in,
  input  logic [DW-1:0] row1_in,
  input  logic [DW-1:0] row2_in,
  output logic [DW-1:0] mag_out,
  output logic          edge_out,
  output logic          valid_out,
  output logic          eol_out
);

  localparam int GW = DW + 3;
  localparam int CW = $clog2(LINE_W);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] COL_FIRST_OUT = CW'(2);
  localparam logic [DW-1:0] THR = DW'(THRESH);

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic [GW-1:0] abs_s(input logic signed [GW-1:0] v);
    return v[GW-1] ? GW'(-v) : GW'(v);
  endfunction

  function automatic logic [DW-1:0] sat_u(input logic [GW-1:0] v);
    return (v[GW-1:DW] != '0) ? {DW{1'b1}} : v[DW-1:0];
  endfunction

  logic [DW-1:0]          w_q [3][3];
  logic [CW-1:0]          col_q, col_d;
  logic                   vld_p0_q, eol_p0_q;
  logic signed [GW-1:0]   gx_p1_q, gy_p1_q, gx_d, gy_d;
  logic                   vld_p1_q, eol_p1_q;
  logic [GW-1:0]          mag_d;
  logic [DW-1:0]          sat_d;
  logic [DW-1:0]          mag_p2_q;
  logic                   edge_p2_q, vld_p2_q, eol_p2_q;

  // Stage p0: window shift and column tracking
  always_comb begin
    col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_q[r][c] <= '0;
      col_q    <= '0;
      vld_p0_q <= 1'b0;
      eol_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= valid_in && (col_q >= COL_FIRST_OUT);
      eol_p0_q <= valid_in && (col_q == COL_LAST);
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          w_q[r][0] <= w_q[r][1];
          w_q[r][1] <= w_q[r][2];
        end
        w_q[0][2] <= row0_in;
        w_q[1][2] <= row1_in;
        w_q[2][2] <= row2_in;
        col_q     <= col_d;
      end
    end
  end

  // Stage p1: signed gradients
  always_comb begin
    gx_d = (ext(w_q[0][2]) + (ext(w_q[1][2]) <<< 1) + ext(w_q[2][2]))
         - (ext(w_q[0][0]) + (ext(w_q[1][0]) <<< 1) + ext(w_q[2][0]));
    gy_d = (ext(w_q[2][0]) + (ext(w_q[2][1]) <<< 1) + ext(w_q[2][2]))
         - (ext(w_q[0][0]) + (ext(w_q[0][1]) <<< 1) + ext(w_q[0][2]));
  end

  always_ff @(posedge clk) begin
    if (vld_p0_q) begin
      gx_p1_q <= gx_d;
      gy_p1_q <= gy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      eol_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p0_q;
      eol_p1_q <= eol_p0_q;
    end
  end

  // Stage p2: magnitude, saturation, threshold; data holds between valids
  always_comb begin
    mag_d = abs_s(gx_p1_q) + abs_s(gy_p1_q);
    sat_d = sat_u(mag_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_p2_q  <= '0;
      edge_p2_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      eol_p2_q  <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      eol_p2_q <= eol_p1_q;
      if (vld_p1_q) begin
        mag_p2_q  <= sat_d;
        edge_p2_q <= (sat_d >= THR);
      end
    end
  end

  assign mag_out   = mag_p2_q;
  assign edge_out  = edge_p2_q;
  assign valid_out = vld_p2_q;
  assign eol_out   = eol_p2_q;

endmodule

// File: tb/tb_sobel_core.sv
// Randomized and directed bench for sobel_core against a kernel-table
// reference model with a timestamped expectation queue.
module tb_sobel_core;

  localparam int DW     = 10;
  localparam int LINE_W = 480;
  localparam int THRESH = 128;
  localparam int MAXV   = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] row0_in = '0, row1_in = '0, row2_in = '0;
  logic [DW-1:0] mag_out;
  logic          edge_out, valid_out, eol_out;

  sobel_core #(.DW(DW), .LINE_W(LINE_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in),
    .mag_out(mag_out), .edge_out(edge_out), .valid_out(valid_out), .eol_out(eol_out)
  );

  always #5 clk = ~clk;

  typedef struct { int mag; int edg; int eol; int cyc; } exp_t;
  exp_t q[$];

  int   cyc = 0;
  logic rst_smp = 1'b0;
  bit   mon_en = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   hist[3][3];
  int   mcol = 0;
  int   last_mag = 0, last_edg = 0;
  int   vcnt = 0, ecnt = 0, eolcnt = 0;

  // Sobel kernels indexed [row][col], col 2 = newest
  int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic send(input int a, input int b, input int c);
    int gx, gy, m;
    int px[3];
    px[0] = a; px[1] = b; px[2] = c;
    valid_in = 1'b1;
    row0_in  = DW'(a);
    row1_in  = DW'(b);
    row2_in  = DW'(c);
    for (int r = 0; r < 3; r++) begin
      hist[r][0] = hist[r][1];
      hist[r][1] = hist[r][2];
      hist[r][2] = px[r];
    end
    if (mcol >= 2) begin
      gx = 0; gy = 0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) begin
          gx += KX[r][k] * hist[r][k];
          gy += KY[r][k] * hist[r][k];
        end
      m = iabs(gx) + iabs(gy);
      if (m > MAXV) m = MAXV;
      q.push_back('{m, (m >= THRESH) ? 1 : 0, (mcol == LINE_W - 1) ? 1 : 0, cyc + 3});
    end
    mcol = (mcol + 1) % LINE_W;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    mcol = 0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) hist[r][k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      0: return 100;
      1: return c;
      2: return (c < 240) ? 0 : MAXV;
      3: return (r == 2) ? 200 : 0;
      default: return $urandom_range(0, MAXV);
    endcase
  endfunction

  task automatic run_line(input int kind, input int gap_col, input int gap_len, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      if (c == gap_col) idle(gap_len);
      if (kind == 4 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      send(pix(kind, 0, c), pix(kind, 1, c), pix(kind, 2, c));
    end
  endtask

  task automatic clr_counts();
    vcnt = 0; ecnt = 0; eolcnt = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_smp) begin
        check_eq("rst_valid_out", valid_out, 0);
        check_eq("rst_mag_out", mag_out, 0);
        check_eq("rst_edge_out", edge_out, 0);
        check_eq("rst_eol_out", eol_out, 0);
        last_mag = 0;
        last_edg = 0;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          check_eq("output_missed_at_cycle", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        check_eq("valid_out", valid_out, (q.size() > 0 && q[0].cyc == cyc) ? 1 : 0);
        if (valid_out && q.size() > 0 && q[0].cyc == cyc) begin
          check_eq("mag_out", mag_out, q[0].mag);
          check_eq("edge_out", edge_out, q[0].edg);
          check_eq("eol_out", eol_out, q[0].eol);
          last_mag = q[0].mag;
          last_edg = q[0].edg;
          void'(q.pop_front());
          vcnt++;
          ecnt += edge_out;
          eolcnt += eol_out;
        end else if (!valid_out) begin
          check_eq("mag_hold", mag_out, last_mag);
          check_eq("edge_hold", edge_out, last_edg);
          check_eq("eol_idle", eol_out, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) hist[r][k] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    clr_counts(); run_line(0, -1, 0, LINE_W); idle(5);
    check_eq("const_count", vcnt, LINE_W - 2);
    check_eq("const_eol", eolcnt, 1);
    check_eq("const_edges", ecnt, 0);

    clr_counts(); run_line(1, -1, 0, LINE_W); idle(5);
    check_eq("ramp_count", vcnt, LINE_W - 2);
    check_eq("ramp_edges", ecnt, 0);

    clr_counts(); run_line(2, -1, 0, LINE_W); idle(5);
    check_eq("vstep_edges", ecnt, 2);
    check_eq("vstep_count", vcnt, LINE_W - 2);

    clr_counts(); run_line(3, -1, 0, LINE_W); idle(5);
    check_eq("hstep_edges", ecnt, LINE_W - 2);
    check_eq("hstep_eol", eolcnt, 1);

    clr_counts(); run_line(1, 100, 5, LINE_W); idle(5);
    check_eq("gap_count", vcnt, LINE_W - 2);
    check_eq("gap_eol", eolcnt, 1);

    clr_counts(); run_line(4, -1, 0, LINE_W); run_line(4, -1, 0, LINE_W); idle(5);
    check_eq("rand_count", vcnt, 2 * (LINE_W - 2));
    check_eq("rand_eol", eolcnt, 2);

    run_line(1, -1, 0, 300);
    do_reset();
    clr_counts(); run_line(3, -1, 0, LINE_W); idle(5);
    check_eq("post_rst_count", vcnt, LINE_W - 2);
    check_eq("post_rst_eol", eolcnt, 1);
    check_eq("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
